// File: rtl/fu_issue_arbiter_if.sv
// Issue-arbiter bus between the reservation station (master) and fu_issue_arbiter (slave).
// ARB_PERF_CNT_EN adds the perf_issued / perf_stall counters to the slave side.
interface fu_issue_arbiter_if #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned IDX_W   = $clog2(RS_SIZE)
);
  logic               flush;
  logic [RS_SIZE-1:0] req_valid;
  logic [RS_SIZE-1:0] req_is_mem;
  logic               lsu_done;
  logic               alu0_gnt_vld;
  logic [IDX_W-1:0]   alu0_gnt_idx;
  logic               alu1_gnt_vld;
  logic [IDX_W-1:0]   alu1_gnt_idx;
  logic               lsu_gnt_vld;
  logic [IDX_W-1:0]   lsu_gnt_idx;
  logic [RS_SIZE-1:0] issue_clr;
  logic [2:0]         fu_ready;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]        perf_issued;
  logic [31:0]        perf_stall;

  modport master (
    output flush, req_valid, req_is_mem, lsu_done,
    input  alu0_gnt_vld, alu0_gnt_idx, alu1_gnt_vld, alu1_gnt_idx,
    input  lsu_gnt_vld, lsu_gnt_idx, issue_clr, fu_ready, perf_issued, perf_stall
  );
  modport slave (
    input  flush, req_valid, req_is_mem, lsu_done,
    output alu0_gnt_vld, alu0_gnt_idx, alu1_gnt_vld, alu1_gnt_idx,
    output lsu_gnt_vld, lsu_gnt_idx, issue_clr, fu_ready, perf_issued, perf_stall
  );
`else
  modport master (
    output flush, req_valid, req_is_mem, lsu_done,
    input  alu0_gnt_vld, alu0_gnt_idx, alu1_gnt_vld, alu1_gnt_idx,
    input  lsu_gnt_vld, lsu_gnt_idx, issue_clr, fu_ready
  );
  modport slave (
    input  flush, req_valid, req_is_mem, lsu_done,
    output alu0_gnt_vld, alu0_gnt_idx, alu1_gnt_vld, alu1_gnt_idx,
    output lsu_gnt_vld, lsu_gnt_idx, issue_clr, fu_ready
  );
`endif
endinterface

// File: rtl/fu_issue_arbiter.sv
// Issue scheduler: round-robin picks of ready RS entries onto ALU0, ALU1 and the LSU,
// with registered grants. Define ARB_PERF_CNT_EN to add issue/stall performance counters.
module fu_issue_arbiter #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned IDX_W   = $clog2(RS_SIZE),
  parameter int unsigned ALU_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  fu_issue_arbiter_if.slave bus
);

  localparam logic [0:0]         StIdle  = 1'b0;
  localparam logic [0:0]         StBusy  = 1'b1;
  localparam logic [2:0]         AluLoad = 3'(ALU_LAT - 1);
  localparam logic [RS_SIZE-1:0] OneHot0 = RS_SIZE'(1);

  logic               alu0_vld_q, alu0_vld_d, alu1_vld_q, alu1_vld_d, lsu_vld_q, lsu_vld_d;
  logic [IDX_W-1:0]   alu0_idx_q, alu0_idx_d, alu1_idx_q, alu1_idx_d, lsu_idx_q, lsu_idx_d;
  logic [RS_SIZE-1:0] issue_clr_q, issue_clr_d;
  logic [2:0]         fu_ready_q, fu_ready_d;
  logic [2:0]         alu0_cnt_q, alu0_cnt_d, alu1_cnt_q, alu1_cnt_d;
  logic [0:0]         lsu_st_q, lsu_st_d;
  logic [IDX_W-1:0]   rr_alu_q, rr_alu_d, rr_mem_q, rr_mem_d;

  logic [RS_SIZE-1:0] alu_cand, mem_cand;
  logic               a_hit, b_hit, m_hit;
  logic [IDX_W-1:0]   a_idx, b_idx, m_idx, scan_a, scan_m;
  logic               alu0_free, alu1_free, lsu_free;
  logic               g0, g1, gl;
  logic [IDX_W-1:0]   i0, i1, il;

  // Entries whose RS clear is still in flight must not be picked again.
  assign alu_cand = bus.req_valid & ~bus.req_is_mem & ~issue_clr_q;
  assign mem_cand = bus.req_valid & bus.req_is_mem & ~issue_clr_q;

  always_comb begin
    a_hit  = 1'b0;
    b_hit  = 1'b0;
    m_hit  = 1'b0;
    a_idx  = '0;
    b_idx  = '0;
    m_idx  = '0;
    scan_a = '0;
    scan_m = '0;
    for (int unsigned k = 0; k < RS_SIZE; k++) begin
      scan_a = rr_alu_q + IDX_W'(k);
      scan_m = rr_mem_q + IDX_W'(k);
      if (alu_cand[scan_a]) begin
        if (!a_hit) begin
          a_hit = 1'b1;
          a_idx = scan_a;
        end else if (!b_hit) begin
          b_hit = 1'b1;
          b_idx = scan_a;
        end
      end
      if (mem_cand[scan_m] && !m_hit) begin
        m_hit = 1'b1;
        m_idx = scan_m;
      end
    end
  end

  assign alu0_free = (alu0_cnt_q == 3'd0);
  assign alu1_free = (alu1_cnt_q == 3'd0);
  // A done pulse frees the LSU for a back-to-back grant in the same cycle.
  assign lsu_free  = (lsu_st_q == StIdle) || bus.lsu_done;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    i0 = '0;
    i1 = '0;
    if (alu0_free && alu1_free) begin
      g0 = a_hit;
      i0 = a_hit ? a_idx : '0;
      g1 = b_hit;
      i1 = b_hit ? b_idx : '0;
    end else if (alu0_free) begin
      g0 = a_hit;
      i0 = a_hit ? a_idx : '0;
    end else if (alu1_free) begin
      g1 = a_hit;
      i1 = a_hit ? a_idx : '0;
    end
    gl = m_hit && lsu_free;
    il = gl ? m_idx : '0;
  end

  always_comb begin
    alu0_vld_d  = g0;
    alu1_vld_d  = g1;
    lsu_vld_d   = gl;
    alu0_idx_d  = i0;
    alu1_idx_d  = i1;
    lsu_idx_d   = il;
    issue_clr_d = (g0 ? (OneHot0 << i0) : '0) | (g1 ? (OneHot0 << i1) : '0) |
                  (gl ? (OneHot0 << il) : '0);

    // When both ALUs grant, ALU1 holds the later pick.
    rr_alu_d = rr_alu_q;
    if (g1) begin
      rr_alu_d = i1 + 1'b1;
    end else if (g0) begin
      rr_alu_d = i0 + 1'b1;
    end
    rr_mem_d = gl ? il + 1'b1 : rr_mem_q;

    alu0_cnt_d = g0 ? AluLoad : (alu0_free ? 3'd0 : alu0_cnt_q - 3'd1);
    alu1_cnt_d = g1 ? AluLoad : (alu1_free ? 3'd0 : alu1_cnt_q - 3'd1);

    lsu_st_d = lsu_st_q;
    if (gl) begin
      lsu_st_d = StBusy;
    end else if (lsu_st_q == StBusy && bus.lsu_done) begin
      lsu_st_d = StIdle;
    end

    if (bus.flush) begin
      alu0_vld_d  = 1'b0;
      alu1_vld_d  = 1'b0;
      lsu_vld_d   = 1'b0;
      alu0_idx_d  = '0;
      alu1_idx_d  = '0;
      lsu_idx_d   = '0;
      issue_clr_d = '0;
      rr_alu_d    = '0;
      rr_mem_d    = '0;
      alu0_cnt_d  = 3'd0;
      alu1_cnt_d  = 3'd0;
      lsu_st_d    = StIdle;
    end

    fu_ready_d = {lsu_st_d == StIdle, alu1_cnt_d == 3'd0, alu0_cnt_d == 3'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu0_vld_q  <= 1'b0;
      alu1_vld_q  <= 1'b0;
      lsu_vld_q   <= 1'b0;
      alu0_idx_q  <= '0;
      alu1_idx_q  <= '0;
      lsu_idx_q   <= '0;
      issue_clr_q <= '0;
      fu_ready_q  <= 3'b111;
      alu0_cnt_q  <= 3'd0;
      alu1_cnt_q  <= 3'd0;
      lsu_st_q    <= StIdle;
      rr_alu_q    <= '0;
      rr_mem_q    <= '0;
    end else begin
      alu0_vld_q  <= alu0_vld_d;
      alu1_vld_q  <= alu1_vld_d;
      lsu_vld_q   <= lsu_vld_d;
      alu0_idx_q  <= alu0_idx_d;
      alu1_idx_q  <= alu1_idx_d;
      lsu_idx_q   <= lsu_idx_d;
      issue_clr_q <= issue_clr_d;
      fu_ready_q  <= fu_ready_d;
      alu0_cnt_q  <= alu0_cnt_d;
      alu1_cnt_q  <= alu1_cnt_d;
      lsu_st_q    <= lsu_st_d;
      rr_alu_q    <= rr_alu_d;
      rr_mem_q    <= rr_mem_d;
    end
  end

  assign bus.alu0_gnt_vld = alu0_vld_q;
  assign bus.alu0_gnt_idx = alu0_idx_q;
  assign bus.alu1_gnt_vld = alu1_vld_q;
  assign bus.alu1_gnt_idx = alu1_idx_q;
  assign bus.lsu_gnt_vld  = lsu_vld_q;
  assign bus.lsu_gnt_idx  = lsu_idx_q;
  assign bus.issue_clr    = issue_clr_q;
  assign bus.fu_ready     = fu_ready_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d, perf_stall_q, perf_stall_d;
  logic [32:0] issued_sum;
  logic [1:0]  n_grants;

  always_comb begin
    n_grants      = {1'b0, alu0_vld_d} + {1'b0, alu1_vld_d} + {1'b0, lsu_vld_d};
    issued_sum    = {1'b0, perf_issued_q} + 33'(n_grants);
    perf_issued_d = issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
    perf_stall_d  = perf_stall_q;
    if (!bus.flush && (|(alu_cand | mem_cand)) && (n_grants == 2'd0) &&
        (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign bus.perf_issued = perf_issued_q;
  assign bus.perf_stall  = perf_stall_q;
`endif

endmodule
